// File: rtl/lt24_pixel_writer_if.sv
// Pixel handshake between the render loop and the LT24 pixel writer.
//   xAddr      : pixel column (0..WIDTH-1)
//   yAddr      : pixel row (0..HEIGHT-1)
//   pixelData  : RGB565 pixel value
//   pixelWrite : source presents a valid pixel
//   pixelReady : writer can accept a pixel this cycle
// master = pixel source, slave = pixel writer.
interface lt24_pixel_writer_if;
   logic [7:0]  xAddr;
   logic [8:0]  yAddr;
   logic [15:0] pixelData;
   logic        pixelWrite;
   logic        pixelReady;

   modport master (
      output xAddr, yAddr, pixelData, pixelWrite,
      input  pixelReady
   );

   modport slave (
      input  xAddr, yAddr, pixelData, pixelWrite,
      output pixelReady
   );
endinterface

// File: rtl/lt24_pixel_writer.sv
// LT24 pixel writer: accepts one pixel per handshake on the pixel interface
// and drives the LT24 8080-style parallel write bus. When the incoming
// address breaks the raster sequence a column/page window command block
// (0x2A, 0x2B, 0x2C) is issued first; otherwise the pixel is streamed as a
// single RAM-write data word.
// Ports:
//   clock, resetApp : system clock, asynchronous active-high reset
//   pix (slave)     : xAddr/yAddr/pixelData/pixelWrite in, pixelReady out
//   LT24Wr_n        : write strobe, active low
//   LT24Rd_n        : read strobe, tied inactive
//   LT24CS_n        : chip select, active low
//   LT24RS          : 0 = command byte, 1 = data word
//   LT24Data        : bus data
//   frameDone       : one-cycle pulse after the data write of the last pixel
module lt24_pixel_writer #(
   parameter int unsigned WIDTH   = 240,
   parameter int unsigned HEIGHT  = 320,
   parameter int unsigned WR_LOW  = 2,
   parameter int unsigned WR_HIGH = 2
) (
   input  logic               clock,
   input  logic               resetApp,
   lt24_pixel_writer_if.slave pix,
   output logic               LT24Wr_n,
   output logic               LT24Rd_n,
   output logic               LT24CS_n,
   output logic               LT24RS,
   output logic [15:0]        LT24Data,
   output logic               frameDone
);

   localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST    = 16'(HEIGHT - 1);
   localparam logic [7:0]  LOW_LAST  = 8'(WR_LOW - 1);
   localparam logic [7:0]  HIGH_LAST = 8'(WR_HIGH - 1);
   localparam logic [3:0]  CMD_LAST  = 4'd10;

   typedef enum logic [1:0] {IDLE_WAIT, IDLE, CMD, DATA} state_t;

   state_t      state;
   logic        ready;
   logic        stream_open;
   logic [7:0]  win_x, exp_x, lat_x;
   logic [8:0]  win_y, exp_y, lat_y;
   logic [15:0] lat_d;
   logic [3:0]  cmd_idx;
   logic        wr_low_phase;
   logic [7:0]  phase_cnt;

   logic        accept;
   logic        out_of_range;
   logic        sequential;
   logic        write_done;
   logic [16:0] first_word;
   logic [16:0] next_word;

   assign pix.pixelReady = ready;
   assign LT24Rd_n       = 1'b1;

   // Window command block, one {RS, data} word per bus write.
   function automatic logic [16:0] cmd_word(input logic [3:0] idx,
                                            input logic [7:0] x,
                                            input logic [8:0] y);
      case (idx)
         4'd0:    return {1'b0, 16'h002A};
         4'd1:    return {1'b1, 16'h0000};
         4'd2:    return {1'b1, 8'h00, x};
         4'd3:    return {1'b1, 16'h0000};
         4'd4:    return {1'b1, 8'h00, X_LAST[7:0]};
         4'd5:    return {1'b0, 16'h002B};
         4'd6:    return {1'b1, 15'h0000, y[8]};
         4'd7:    return {1'b1, 8'h00, y[7:0]};
         4'd8:    return {1'b1, 8'h00, Y_LAST[15:8]};
         4'd9:    return {1'b1, 8'h00, Y_LAST[7:0]};
         default: return {1'b0, 16'h002C};
      endcase
   endfunction

   always_comb begin
      accept       = (state == IDLE) && ready && pix.pixelWrite;
      out_of_range = (9'(pix.xAddr) >= 9'(WIDTH)) || (10'(pix.yAddr) >= 10'(HEIGHT));
      sequential   = stream_open && (pix.xAddr == exp_x) && (pix.yAddr == exp_y);
      first_word   = sequential ? {1'b1, pix.pixelData}
                                : cmd_word(4'd0, pix.xAddr, pix.yAddr);
      // After the last command (0x2C) the pixel data write follows directly.
      next_word    = (cmd_idx == CMD_LAST) ? {1'b1, lat_d}
                                           : cmd_word(cmd_idx + 4'd1, lat_x, lat_y);
      write_done   = !wr_low_phase && (phase_cnt == HIGH_LAST);
   end

   always_ff @(posedge clock or posedge resetApp) begin
      if (resetApp) begin
         state        <= IDLE_WAIT;
         ready        <= 1'b0;
         stream_open  <= 1'b0;
         win_x        <= '0;
         win_y        <= '0;
         exp_x        <= '0;
         exp_y        <= '0;
         lat_x        <= '0;
         lat_y        <= '0;
         lat_d        <= '0;
         cmd_idx      <= '0;
         wr_low_phase <= 1'b0;
         phase_cnt    <= '0;
         LT24Wr_n     <= 1'b1;
         LT24CS_n     <= 1'b1;
         LT24RS       <= 1'b0;
         LT24Data     <= '0;
         frameDone    <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         case (state)
            IDLE_WAIT: begin
               state <= IDLE;
               ready <= 1'b1;
            end

            IDLE: begin
               if (accept) begin
                  ready <= 1'b0;
                  lat_x <= pix.xAddr;
                  lat_y <= pix.yAddr;
                  lat_d <= pix.pixelData;
                  if (out_of_range) begin
                     // Dropped pixel: IDLE_WAIT re-raises pixelReady next cycle.
                     stream_open <= 1'b0;
                     state       <= IDLE_WAIT;
                  end else begin
                     // First bus write starts on the acceptance edge.
                     LT24Wr_n           <= 1'b0;
                     LT24CS_n           <= 1'b0;
                     {LT24RS, LT24Data} <= first_word;
                     wr_low_phase       <= 1'b1;
                     phase_cnt          <= '0;
                     if (sequential) begin
                        state <= DATA;
                     end else begin
                        state   <= CMD;
                        cmd_idx <= '0;
                        win_x   <= pix.xAddr;
                        win_y   <= pix.yAddr;
                     end
                  end
               end
            end

            CMD, DATA: begin
               if (wr_low_phase) begin
                  if (phase_cnt == LOW_LAST) begin
                     LT24Wr_n     <= 1'b1;
                     wr_low_phase <= 1'b0;
                     phase_cnt    <= '0;
                  end else begin
                     phase_cnt <= phase_cnt + 8'd1;
                  end
               end else if (!write_done) begin
                  phase_cnt <= phase_cnt + 8'd1;
               end else if (state == CMD) begin
                  LT24Wr_n           <= 1'b0;
                  {LT24RS, LT24Data} <= next_word;
                  wr_low_phase       <= 1'b1;
                  phase_cnt          <= '0;
                  if (cmd_idx == CMD_LAST) begin
                     stream_open <= 1'b1;
                     state       <= DATA;
                  end else begin
                     cmd_idx <= cmd_idx + 4'd1;
                  end
               end else begin
                  state    <= IDLE;
                  ready    <= 1'b1;
                  LT24CS_n <= 1'b1;
                  // The panel wraps inside the window, so the next expected
                  // address follows the same rule.
                  if (lat_x < X_LAST[7:0]) begin
                     exp_x <= lat_x + 8'd1;
                     exp_y <= lat_y;
                  end else begin
                     exp_x <= win_x;
                     exp_y <= (lat_y == Y_LAST[8:0]) ? win_y : lat_y + 9'd1;
                  end
                  frameDone <= (lat_x == X_LAST[7:0]) && (lat_y == Y_LAST[8:0]);
               end
            end

            default: state <= IDLE_WAIT;
         endcase
      end
   end

endmodule
